// File: rtl/paddle_ctrl.sv
// paddle_ctrl
//   Converts one player's debounced up/down button levels into a clamped
//   paddle position. A press moves the paddle one step at once; holding the
//   button auto-repeats after a hold delay, paced by an internal game tick.
//   One instance per player, between the button debouncers and the renderer.
//
// Ports
//   clk_100MHz   in   1      system clock
//   reset        in   1      synchronous, active-high
//   up_status    in   1      debounced up button, 1 = pressed
//   down_status  in   1      debounced down button, 1 = pressed
//   enable       in   1      game running; 0 freezes the paddle
//   recenter     in   1      one-cycle pulse, returns pos to POS_INIT
//   pos          out  POS_W  paddle top y coordinate, registered
//   moving       out  1      FSM not in IDLE, registered
//   at_limit     out  1      pos sits at POS_MIN or POS_MAX, registered
//
// FSM states
//   state  | meaning
//   IDLE   | no usable direction held; next held direction steps at once
//   DELAY  | first step taken, waiting DELAY_TICKS ticks for first repeat
//   REPEAT | auto-repeat, one step every REPEAT_TICKS ticks
module paddle_ctrl #(
  parameter int POS_W        = 10,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 416,
  parameter int POS_INIT     = 208,
  parameter int STEP         = 4,
  parameter int TICK_DIV     = 1666667,
  parameter int DELAY_TICKS  = 15,
  parameter int REPEAT_TICKS = 3
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             up_status,
  input  logic             down_status,
  input  logic             enable,
  input  logic             recenter,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             at_limit
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T  = (DELAY_TICKS > REPEAT_TICKS) ? DELAY_TICKS : REPEAT_TICKS;
  localparam int RCNT_W = (MAX_T > 1) ? $clog2(MAX_T + 1) : 1;

  // Saturation bounds in POS_W+1 bits so pos-STEP / pos+STEP cannot wrap.
  localparam logic [POS_W:0] UP_FLOOR = (POS_W+1)'(POS_MIN + STEP);
  localparam logic [POS_W:0] DN_CEIL  = (POS_W+1)'(POS_MAX - STEP);
  localparam logic [POS_W:0] STEP_X   = (POS_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t              state, state_nxt;
  dir_t                dir, dir_q;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [RCNT_W-1:0]   rcnt, rcnt_nxt;
  logic                do_step;
  logic [POS_W-1:0]    pos_nxt;

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input dir_t d);
    logic [POS_W:0] w;
    logic [POS_W:0] r;
    w = {1'b0, p};
    r = w;
    case (d)
      DIR_UP:  r = (w < UP_FLOOR) ? (POS_W+1)'(POS_MIN) : w - STEP_X;
      DIR_DN:  r = (w > DN_CEIL)  ? (POS_W+1)'(POS_MAX) : w + STEP_X;
      default: r = w;
    endcase
    return r[POS_W-1:0];
  endfunction

  // Game tick: free-running divider, independent of enable/recenter.
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_100MHz) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Both buttons pressed cancel out.
  always_comb begin
    dir = DIR_NONE;
    if (up_status && !down_status)      dir = DIR_UP;
    else if (down_status && !up_status) dir = DIR_DN;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) dir_q <= DIR_NONE;
    else       dir_q <= dir;
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    do_step   = 1'b0;
    if (recenter || !enable) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          rcnt_nxt = '0;
          if (dir != DIR_NONE) begin
            do_step   = 1'b1;
            state_nxt = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (dir == DIR_NONE) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (dir != dir_q) begin
            // Reversal behaves like a fresh press in the new direction.
            do_step   = 1'b1;
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end else if (tick) begin
            if ((state == DELAY  && rcnt == RCNT_W'(DELAY_TICKS - 1)) ||
                (state == REPEAT && rcnt == RCNT_W'(REPEAT_TICKS - 1))) begin
              do_step   = 1'b1;
              state_nxt = REPEAT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + RCNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pos_nxt = pos;
    if (recenter)     pos_nxt = POS_W'(POS_INIT);
    else if (do_step) pos_nxt = step_pos(pos, dir);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= IDLE;
      rcnt     <= '0;
      pos      <= POS_W'(POS_INIT);
      moving   <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      state    <= state_nxt;
      rcnt     <= rcnt_nxt;
      pos      <= pos_nxt;
      moving   <= (state_nxt != IDLE);
      at_limit <= (pos_nxt == POS_W'(POS_MIN)) || (pos_nxt == POS_W'(POS_MAX));
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl
//   Directed vector table plus hand sequences for limits, reversal, recenter
//   and enable, then randomized buttons against a behavioural paddle model.
module tb_paddle_ctrl;

  localparam int POS_W = 10;
  localparam int TD    = 4;
  localparam int DT    = 3;
  localparam int RT    = 2;
  localparam int PMIN  = 0;
  localparam int PMAX  = 416;
  localparam int PINIT = 208;
  localparam int STP   = 4;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic             reset = 1'b1;
  logic             up_status = 1'b0, down_status = 1'b0;
  logic             enable = 1'b1, recenter = 1'b0;
  logic [POS_W-1:0] pos;
  logic             moving, at_limit;

  logic             hi_down = 1'b0, lo_up = 1'b0;
  logic [POS_W-1:0] hi_pos, lo_pos;
  logic             hi_moving, hi_lim, lo_moving, lo_lim;

  paddle_ctrl #(.TICK_DIV(TD), .DELAY_TICKS(DT), .REPEAT_TICKS(RT)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .up_status(up_status),
    .down_status(down_status), .enable(enable), .recenter(recenter),
    .pos(pos), .moving(moving), .at_limit(at_limit));

  paddle_ctrl #(.POS_INIT(414), .TICK_DIV(TD), .DELAY_TICKS(DT), .REPEAT_TICKS(RT)) dut_hi (
    .clk_100MHz(clk_100MHz), .reset(reset), .up_status(1'b0),
    .down_status(hi_down), .enable(1'b1), .recenter(1'b0),
    .pos(hi_pos), .moving(hi_moving), .at_limit(hi_lim));

  paddle_ctrl #(.POS_INIT(2), .TICK_DIV(TD), .DELAY_TICKS(DT), .REPEAT_TICKS(RT)) dut_lo (
    .clk_100MHz(clk_100MHz), .reset(reset), .up_status(lo_up),
    .down_status(1'b0), .enable(1'b1), .recenter(1'b0),
    .pos(lo_pos), .moving(lo_moving), .at_limit(lo_lim));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a hold is "active" once its first step is taken;
  // the next step falls due after m_need ticks (first DT, then RT).
  int m_pos = PINIT, m_tcnt = 0, m_ticks = 0, m_need = DT, m_hdir = 0;
  bit m_active = 1'b0;

  task automatic model_move(input int d);
    if (d == 1) m_pos = (m_pos - STP < PMIN) ? PMIN : m_pos - STP;
    else        m_pos = (m_pos + STP > PMAX) ? PMAX : m_pos + STP;
  endtask

  task automatic model_edge();
    bit tick;
    int d;
    tick   = (m_tcnt == TD - 1);
    m_tcnt = (m_tcnt + 1) % TD;
    d = (up_status && !down_status) ? 1 : (down_status && !up_status) ? 2 : 0;
    if (reset) begin
      m_pos = PINIT; m_active = 0; m_tcnt = 0;
    end else if (recenter) begin
      m_pos = PINIT; m_active = 0;
    end else if (!enable || d == 0) begin
      m_active = 0;
    end else if (!m_active || d != m_hdir) begin
      model_move(d);
      m_active = 1; m_hdir = d; m_ticks = 0; m_need = DT;
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == m_need) begin
        model_move(m_hdir);
        m_ticks = 0; m_need = RT;
      end
    end
  endtask

  task automatic cyc(input bit u, input bit d, input bit en, input bit rc);
    @(negedge clk_100MHz);
    up_status = u; down_status = d; enable = en; recenter = rc;
    model_edge();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) cyc(0, 0, 1, 0);
    reset = 1'b0;
  endtask

  typedef struct {
    bit u, d, en, rc;
    int n;
    int pos;
    bit mov, lim;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0,0,1,0,100,208,0,0};
    tbl[1]  = '{1,0,1,0,  1,204,1,0};
    tbl[2]  = '{1,0,1,0,  4,204,1,0};
    tbl[3]  = '{0,0,1,0,  1,204,0,0};
    tbl[4]  = '{0,0,1,1,  1,208,0,0};
    tbl[5]  = '{0,0,1,0,  1,208,0,0};
    tbl[6]  = '{0,1,1,0, 11,212,1,0};
    tbl[7]  = '{0,1,1,0,  8,216,1,0};
    tbl[8]  = '{0,1,1,0,  8,220,1,0};
    tbl[9]  = '{0,1,1,0,  8,224,1,0};
    tbl[10] = '{0,1,1,0,  5,228,1,0};
    tbl[11] = '{0,0,1,0,  4,228,0,0};

    do_reset();
    check("reset_pos", pos, PINIT);
    check("reset_moving", moving, 0);
    check("reset_at_limit", at_limit, 0);
    check("reset_hi_pos", hi_pos, 414);
    check("reset_hi_lim", hi_lim, 0);

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc(tbl[i].u, tbl[i].d, tbl[i].en, tbl[i].rc);
        check($sformatf("tbl%0d_pos", i), pos, tbl[i].pos);
        check($sformatf("tbl%0d_moving", i), moving, tbl[i].mov);
        check($sformatf("tbl%0d_at_limit", i), at_limit, tbl[i].lim);
      end
    end

    // Saturation at both ends, on the offset-init instances.
    do_reset();
    hi_down = 1'b1; lo_up = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 1, 0);
      check("hi_pos", hi_pos, PMAX);
      check("hi_lim", hi_lim, 1);
      check("hi_moving", hi_moving, 1);
      check("lo_pos", lo_pos, PMIN);
      check("lo_lim", lo_lim, 1);
      check("lo_moving", lo_moving, 1);
    end
    hi_down = 1'b0; lo_up = 1'b0;
    cyc(0, 0, 1, 0);
    check("hi_release_moving", hi_moving, 0);
    check("hi_release_lim", hi_lim, 1);
    check("lo_release_lim", lo_lim, 1);

    // Both buttons held: no motion.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      cyc(1, 1, 1, 0);
      check("both_pos", pos, PINIT);
      check("both_moving", moving, 0);
    end

    // Reversal mid-REPEAT restarts DELAY.
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      int exp_p;
      if (e <= 21) begin
        cyc(1, 0, 1, 0);
        exp_p = (e < 12) ? 204 : (e < 20) ? 200 : 196;
      end else begin
        cyc(0, 1, 1, 0);
        exp_p = (e < 32) ? 200 : 204;
      end
      check($sformatf("rev_e%0d_pos", e), pos, exp_p);
      check($sformatf("rev_e%0d_moving", e), moving, 1);
    end

    // Recenter during REPEAT at 300, then enable gating.
    do_reset();
    for (int e = 1; e <= 183; e++) begin
      cyc(0, 1, 1, 0);
      if (e == 1)  check("rc_first_step", pos, 212);
      if (e == 12) check("rc_first_repeat", pos, 216);
    end
    check("rc_pre_pos", pos, 300);
    check("rc_pre_moving", moving, 1);
    cyc(0, 1, 1, 1);
    check("rc_pos", pos, PINIT);
    check("rc_moving", moving, 0);
    cyc(0, 1, 1, 0);
    check("rc_restep_pos", pos, 212);
    check("rc_restep_moving", moving, 1);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 0, 0);
      check("dis_pos", pos, 212);
      check("dis_moving", moving, 0);
    end
    cyc(0, 1, 1, 0);
    check("reen_pos", pos, 216);
    check("reen_moving", moving, 1);

    // Randomized buttons against the model.
    do_reset();
    begin
      bit ru, rd, ren;
      ru = 0; rd = 0; ren = 1;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(0, 15) == 0) ru = ~ru;
        if ($urandom_range(0, 15) == 0) rd = ~rd;
        if ($urandom_range(0, 63) == 0) ren = ~ren;
        reset = ($urandom_range(0, 499) == 0);
        cyc(ru, rd, ren, $urandom_range(0, 199) == 0);
        check("rand_pos", pos, m_pos);
        check("rand_moving", moving, m_active);
        check("rand_at_limit", at_limit, (!reset) && (m_pos == PMIN || m_pos == PMAX));
      end
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
